// File: rtl/regbank_pkg.sv
// Shared widths and enums for the register-bank write arbiter.
// Source/state enums give the registered grant and starvation state a readable debug view.
package regbank_pkg;

    localparam int REG_ADDR_W = 6;
    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT  = 64;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_WB   = 2'd1,
        SRC_MU   = 2'd2
    } src_e;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCED = 1'b1
    } wait_state_e;

endpackage

// File: rtl/regbank_starve_cnt.sv
// Saturating count of consecutive cycles the MU request was blocked.
// forced is raised once the count reaches MAX_WAIT (legal range 1..15).
module regbank_starve_cnt
    import regbank_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        inc,
    output logic        forced,
    output logic [3:0]  cnt,
    output wait_state_e state
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (inc && (cnt_q != MAX_CNT)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign forced = (cnt_q == MAX_CNT);
    assign cnt    = cnt_q;
    assign state  = forced ? ST_FORCED : ST_NORMAL;

endmodule

// File: rtl/regbank_wr_arbiter.sv
// Arbitrates the single bank write port between WB (priority) and MU, with a starvation
// guard and WAW squash. Define REGBANK_R0_DISCARD_EN to suppress writes to register 0.
module regbank_wr_arbiter
    import regbank_pkg::*;
#(
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int DATA_W   = REG_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_stall,
    input  logic              mu_valid,
    input  logic [ADDR_W-1:0] mu_addr,
    input  logic [DATA_W-1:0] mu_data,
    output logic              mu_ready,
    output logic [ADDR_W-1:0] bank_addr,
    output logic              bank_we,
    output logic [DATA_W-1:0] bank_wdata,
    output src_e              dbg_src,
    output wait_state_e       dbg_state,
    output logic [3:0]        dbg_wait_cnt
);

    logic              forced;
    logic              grant_mu;
    logic              grant_wb;
    logic              squash;

    logic [ADDR_W-1:0] bank_addr_q,  bank_addr_d;
    logic [DATA_W-1:0] bank_wdata_q, bank_wdata_d;
    logic              bank_we_q,    bank_we_d;
    src_e              src_q,        src_d;

    regbank_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (!mu_valid || mu_ready),
        .inc    (mu_valid && !mu_ready),
        .forced (forced),
        .cnt    (dbg_wait_cnt),
        .state  (dbg_state)
    );

    always_comb begin
        grant_mu     = mu_valid && (!wb_valid || forced);
        grant_wb     = wb_valid && !grant_mu;
        // A same-address MU write loses to the newer WB value unless the MU was forced through.
        squash       = grant_wb && mu_valid && (mu_addr == wb_addr) && !forced;
        mu_ready     = grant_mu || squash;
        wb_stall     = wb_valid && grant_mu;

        src_d        = SRC_NONE;
        bank_we_d    = 1'b0;
        bank_addr_d  = bank_addr_q;
        bank_wdata_d = bank_wdata_q;
        if (grant_mu) begin
            src_d        = SRC_MU;
            bank_we_d    = 1'b1;
            bank_addr_d  = mu_addr;
            bank_wdata_d = mu_data;
        end else if (grant_wb) begin
            src_d        = SRC_WB;
            bank_we_d    = 1'b1;
            bank_addr_d  = wb_addr;
            bank_wdata_d = wb_data;
        end
`ifdef REGBANK_R0_DISCARD_EN
        if (bank_addr_d == '0) begin
            bank_we_d = 1'b0;
        end
`else
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_addr_q  <= '0;
            bank_wdata_q <= '0;
            bank_we_q    <= 1'b0;
            src_q        <= SRC_NONE;
        end else begin
            bank_addr_q  <= bank_addr_d;
            bank_wdata_q <= bank_wdata_d;
            bank_we_q    <= bank_we_d;
            src_q        <= src_d;
        end
    end

    assign bank_addr  = bank_addr_q;
    assign bank_wdata = bank_wdata_q;
    assign bank_we    = bank_we_q;
    assign dbg_src    = src_q;

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Bench for regbank_wr_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model and a queue of expected bank writes.
module tb_regbank_wr_arbiter;
    import regbank_pkg::*;

    localparam int MAX_WAIT = 4;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        mu_valid;
    logic [5:0]  mu_addr;
    logic [31:0] mu_data;
    logic        mu_ready;
    logic [5:0]  bank_addr;
    logic        bank_we;
    logic [31:0] bank_wdata;
    src_e        dbg_src;
    wait_state_e dbg_state;
    logic [3:0]  dbg_wait_cnt;

    regbank_wr_arbiter #(
        .ADDR_W   (6),
        .DATA_W   (32),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_stall     (wb_stall),
        .mu_valid     (mu_valid),
        .mu_addr      (mu_addr),
        .mu_data      (mu_data),
        .mu_ready     (mu_ready),
        .bank_addr    (bank_addr),
        .bank_we      (bank_we),
        .bank_wdata   (bank_wdata),
        .dbg_src      (dbg_src),
        .dbg_state    (dbg_state),
        .dbg_wait_cnt (dbg_wait_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [37:0] exp_q[$];

    // behavioural model state
    int          m_wait;
    logic        m_we;
    logic [5:0]  m_addr;
    logic [31:0] m_data;
    int          m_src;
    logic        exp_ready;
    logic        exp_stall;
    logic        dut_ready;
    logic        dut_stall;
    logic        saw_22;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wait    = 0;
        m_we      = 1'b0;
        m_addr    = '0;
        m_data    = '0;
        m_src     = 0;
        exp_ready = 1'b0;
        exp_stall = 1'b0;
        exp_q.delete();
    endtask

    // Called just after a rising edge with inputs already applied; returns just after the next edge.
    task automatic step();
        int          win;
        logic        mf;
        logic        nwe;
        logic [5:0]  na;
        logic [31:0] nd;
        logic [37:0] ent;
        #3;
        mf  = (m_wait == MAX_WAIT);
        win = 0;
        if (mu_valid && (!wb_valid || mf)) win = 2;
        else if (wb_valid)                 win = 1;
        exp_ready = (win == 2) || (win == 1 && mu_valid && (mu_addr == wb_addr) && !mf);
        exp_stall = wb_valid && (win == 2);
        dut_ready = mu_ready;
        dut_stall = wb_stall;
        check("mu_ready", mu_ready, exp_ready);
        check("wb_stall", wb_stall, exp_stall);

        nwe = 1'b0;
        na  = m_addr;
        nd  = m_data;
        if (win == 2) begin
            nwe = 1'b1; na = mu_addr; nd = mu_data;
        end else if (win == 1) begin
            nwe = 1'b1; na = wb_addr; nd = wb_data;
        end
`ifdef REGBANK_R0_DISCARD_EN
        if (na == 6'd0) nwe = 1'b0;
`else
`endif
        if (nwe) exp_q.push_back({na, nd});
        if (mu_valid && !exp_ready) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
        else                        m_wait = 0;

        @(posedge clk);
        #1;
        m_we   = nwe;
        m_addr = na;
        m_data = nd;
        m_src  = win;
        check("bank_we",    bank_we,    m_we);
        check("bank_addr",  bank_addr,  m_addr);
        check("bank_wdata", bank_wdata, m_data);
        check("dbg_src",    int'(dbg_src), m_src);
        check("wait_cnt",   dbg_wait_cnt, m_wait);
        check("dbg_state",  dbg_state, (m_wait == MAX_WAIT));
        if (bank_we) begin
            check("sb_pending", (exp_q.size() > 0), 1'b1);
            if (exp_q.size() > 0) begin
                ent = exp_q.pop_front();
                check("sb_write", {bank_addr, bank_wdata}, ent);
            end
            if (bank_wdata == 32'h22) saw_22 = 1'b1;
        end
    endtask

    task automatic idle();
        wb_valid = 1'b0;
        mu_valid = 1'b0;
        step();
    endtask

    initial begin
        int cyc;
        int found;
        int idx;

        reset    = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        mu_valid = 1'b0; mu_addr = '0; mu_data = '0;
        saw_22   = 1'b0;
        model_reset();
        #1;
        check("rst_we",    bank_we,    1'b0);
        check("rst_addr",  bank_addr,  6'd0);
        check("rst_wdata", bank_wdata, 32'd0);
        check("rst_wait",  dbg_wait_cnt, 4'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // WB only
        wb_valid = 1'b1; wb_addr = 6'd2; wb_data = 32'h85;
        step();
        check("wbonly_stall", dut_stall, 1'b0);
        check("wbonly_we",    bank_we,    1'b1);
        check("wbonly_addr",  bank_addr,  6'd2);
        check("wbonly_data",  bank_wdata, 32'h85);
        idle();
        check("wbonly_idle_we", bank_we, 1'b0);

        // MU only
        mu_valid = 1'b1; mu_addr = 6'd5; mu_data = 32'hDEADBEEF;
        step();
        check("muonly_ready", dut_ready, 1'b1);
        check("muonly_addr",  bank_addr,  6'd5);
        check("muonly_data",  bank_wdata, 32'hDEADBEEF);
        check("muonly_wait",  dbg_wait_cnt, 4'd0);
        idle();

        // WAW squash
        saw_22 = 1'b0;
        wb_valid = 1'b1; wb_addr = 6'd3; wb_data = 32'h11;
        mu_valid = 1'b1; mu_addr = 6'd3; mu_data = 32'h22;
        step();
        check("waw_ready", dut_ready, 1'b1);
        check("waw_addr",  bank_addr,  6'd3);
        check("waw_data",  bank_wdata, 32'h11);
        idle();
        check("waw_single_we", bank_we, 1'b0);
        check("waw_no_stale",  saw_22,  1'b0);

        // Starvation: WB streams addrs 1..8, MU waits on addr 9
        mu_valid = 1'b1; mu_addr = 6'd9; mu_data = 32'h9999;
        idx = 1; cyc = 0; found = 0;
        while (idx <= 8 && cyc < 30) begin
            wb_valid = 1'b1; wb_addr = 6'(idx); wb_data = 32'h100 + 32'(idx);
            step();
            cyc++;
            if (dut_ready && mu_valid) begin
                found = cyc;
                check("starve_stall", dut_stall, 1'b1);
                check("starve_mu_addr", bank_addr, 6'd9);
                mu_valid = 1'b0;
            end else if (found == cyc - 1 && found != 0) begin
                check("starve_wb_after", bank_addr, 6'd5);
                check("starve_wb_data",  bank_wdata, 32'h105);
            end
            if (!dut_stall) idx++;
        end
        check("starve_cycle", found, 5);
        idle();

        // Async reset mid-starvation
        idle();
        wb_valid = 1'b1; mu_valid = 1'b1; mu_addr = 6'd20; mu_data = 32'hA5A5;
        for (int i = 0; i < 3; i++) begin
            wb_addr = 6'(30 + i); wb_data = 32'(i);
            step();
        end
        check("prerst_wait", dbg_wait_cnt, 4'd3);
        check("prerst_we",   bank_we,      1'b1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("midrst_we",    bank_we,      1'b0);
        check("midrst_addr",  bank_addr,    6'd0);
        check("midrst_wait",  dbg_wait_cnt, 4'd0);
        check("midrst_ready", mu_ready,     1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc = 0; found = 0;
        while (found == 0 && cyc < 20) begin
            wb_addr = 6'(40 + cyc); wb_data = 32'(cyc);
            step();
            cyc++;
            if (dut_ready) found = cyc;
        end
        check("postrst_force_cycle", found, 5);
        mu_valid = 1'b0;
        step();
        idle();

        // Register 0 write
        wb_valid = 1'b1; wb_addr = 6'd0; wb_data = 32'hFF;
        step();
        check("r0_stall", dut_stall, 1'b0);
`ifdef REGBANK_R0_DISCARD_EN
        check("r0_we", bank_we, 1'b0);
`else
        check("r0_we",   bank_we,   1'b1);
        check("r0_addr", bank_addr, 6'd0);
`endif
        idle();

        // Randomized traffic obeying the hold rules of both requesters
        for (int n = 0; n < 400; n++) begin
            if (!(wb_valid && exp_stall)) begin
                wb_valid = ($urandom_range(0, 3) != 0);
                wb_addr  = 6'($urandom_range(0, 7));
                wb_data  = $urandom;
            end
            if (!(mu_valid && !exp_ready)) begin
                mu_valid = ($urandom_range(0, 2) == 0);
                mu_addr  = 6'($urandom_range(0, 7));
                mu_data  = $urandom;
            end
            step();
        end
        idle();
        idle();
        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
